vmul_op_sequencer: RTL
======================

// Module: vmul_op_sequencer
// PURPOSE
// Issue controller for the vector multiplier. Accepts one op (opcode, precision, A, B) per valid/ready
// handshake and registers the operands into the two's-complement conditioning stage. It captures the
// per-byte sign flags that stage returns, starts the Vedic array and counts its fixed latency. It then
// presents the result-fixup controls (negate mask, high-half select) to the result stage.
// Supported ops: MUL/MULH/MULHU/MULSU = 00/01/10/11. Precision: 8/16/32 = 00/01/10; 11 is treated as 8.
// PARAMETERS
// MUL_LATENCY  3  cycles from mul_start to product valid in the array; legal range 1..15
// PORTS
// clk            in   1   clock; all state updates on posedge
// rst            in   1   synchronous reset, active-high
// req_valid      in   1   request valid
// req_ready      out  1   request ready
// req_opcode     in   2   operation
// req_precision  in   2   lane precision
// req_operand_a  in   32  operand A
// req_operand_b  in   32  operand B
// dp_opcode      out  2   registered opcode to conditioning stage and array
// dp_precision   out  2   registered precision
// dp_operand_a   out  32  registered operand A
// dp_operand_b   out  32  registered operand B
// dp_sign_a      in   4   per-byte sign flags returned for A (valid while in COND)
// dp_sign_b      in   4   per-byte sign flags returned for B (valid while in COND)
// mul_start      out  1   one-cycle start pulse to the array
// rsp_valid      out  1   fixup controls valid
// rsp_ready      in   1   result stage ready
// rsp_neg_mask   out  4   per-byte negate mask for the product
// rsp_sel_high   out  1   1 = return high half of each lane product
// rsp_precision  out  2   precision of the op being returned
// busy           out  1   state != IDLE
// BEHAVIOUR
// - Reset values (while rst=1 and the cycle after):
//   - state = IDLE; dp_* = 0; rsp_neg_mask, rsp_sel_high, rsp_precision, counter = 0.
//   - mul_start, rsp_valid, busy = 0.
//   - req_ready is forced to 0 while rst=1.
// - States and transitions:
//   - IDLE: req_ready=1. On req_valid, latch req_* into dp_* and go to COND.
//   - COND (1 cycle): mul_start=1. Latch rsp_neg_mask = dp_sign_a ^ dp_sign_b and
//     rsp_sel_high = (dp_opcode != 00). Latch rsp_precision = dp_precision. Load cnt = MUL_LATENCY-1. Go to MUL.
//   - MUL: if cnt==0, go to RESP; else decrement cnt.
//   - RESP: rsp_valid=1; rsp_* held stable until the handshake. On rsp_ready:
//     - with req_valid: latch the new op, go to COND (back-to-back).
//     - otherwise: go to IDLE.
// - req_ready = (state==IDLE) | (state==RESP & rsp_ready). This is a combinational path from rsp_ready; by design.
// - Latency: handshake at edge 0 -> rsp_valid high after edge MUL_LATENCY+1.
// - Throughput: one op per MUL_LATENCY+2 cycles when back-to-back.
// - dp_* change only on an accepted request. They are held through MUL and RESP because the array reads them live.
// - Sign flags are not interpreted: the conditioning stage already zeroes them for unsigned operands
//   (MULHU: both A and B; MULSU: B) and replicates them across a lane. The XOR is therefore correct at every precision.
// - Precision 11 is passed through unchanged; downstream treats it as 8-bit.
// - rst asserted in any state aborts the op. No response is produced and the next cycle is IDLE with reset values.
// - req_valid in COND or MUL is ignored (req_ready=0). No request is dropped silently: the requester holds.
// STRUCTURE
// - Shared package vmul_pkg:
//   - opcode_e {MUL, MULH, MULHU, MULSU}; precision_e {P8, P16, P32, P8_ALT}.
//   - seq_state_e {IDLE, COND, MUL, RESP}; localparam LANES = 4.
// - Single module; no sub-module. The latency counter is inline, width $clog2(MUL_LATENCY+1).
// TESTING
// - Reset: hold rst 3 cycles, with req_valid=1 -> req_ready=0 throughout; the cycle after release: IDLE,
//   req_ready=1, all outputs 0.
// - MUL, P8, A=0x80FF0102, B=0x01FF80FE, bench drives signs from conditioning instances
//   (sign_a=1100, sign_b=0111) -> rsp_neg_mask=1011, rsp_sel_high=0, rsp_valid after edge 4 (MUL_LATENCY=3).
// - MULHU, P16, A=0xFFFF8000, B=0x80000001 -> signs 0000/0000, rsp_neg_mask=0000, rsp_sel_high=1.
// - MULSU, P32, A=0xFFFFFFF0, B=0x80000000 -> sign_a=1111, sign_b=0000, rsp_neg_mask=1111, rsp_sel_high=1.
// - Backpressure and back-to-back:
//   - rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0.
//   - Then rsp_ready=1 with req_valid=1 -> new op latched the same edge, COND next cycle, mul_start exactly one cycle.
// - Abort: rst pulse while in MUL (cnt=1) -> no rsp_valid, busy=0 next cycle, a following op completes with correct latency.

Source files
------------

// File: rtl/vmul_pkg.sv
// Shared types for the vector multiplier issue path.
//   opcode_e    : MUL / MULH / MULHU / MULSU encodings (00..11)
//   precision_e : lane width 8 / 16 / 32; the fourth code is an alias of 8
//   seq_state_e : op sequencer states
//   LANES       : number of byte lanes carrying sign flags and negate bits
package vmul_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMulh  = 2'b01,
        OpMulhu = 2'b10,
        OpMulsu = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        PrecP8    = 2'b00,
        PrecP16   = 2'b01,
        PrecP32   = 2'b10,
        PrecP8Alt = 2'b11
    } precision_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCond = 2'b01,
        StMul  = 2'b10,
        StResp = 2'b11
    } seq_state_e;

    // Every op except plain MUL returns the upper half of each lane product.
    function automatic logic is_high_half(input opcode_e op);
        return op != OpMul;
    endfunction

endpackage

// File: rtl/vmul_op_sequencer.sv
// Issue controller for the vector multiplier.
// Accepts one op per req handshake, registers it into the conditioning stage (dp_*),
// captures the per-byte sign flags returned from that stage, pulses mul_start to the
// Vedic array, waits out its fixed latency and then holds the result-fixup controls
// (rsp_*) until the result stage takes them.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_*             op request (valid/ready handshake): opcode, precision, A, B
//   dp_*              registered op to the datapath; dp_sign_a/b are sign flags back from it
//   mul_start         one-cycle start pulse to the array
//   rsp_*             fixup controls (negate mask, high-half select, precision) with handshake
//   busy              high whenever an op is in flight
module vmul_op_sequencer
    import vmul_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3  // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_opcode,
    input  logic [1:0]           req_precision,
    input  logic [31:0]          req_operand_a,
    input  logic [31:0]          req_operand_b,
    output logic [1:0]           dp_opcode,
    output logic [1:0]           dp_precision,
    output logic [31:0]          dp_operand_a,
    output logic [31:0]          dp_operand_b,
    input  logic [LANES-1:0]     dp_sign_a,
    input  logic [LANES-1:0]     dp_sign_b,
    output logic                 mul_start,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LANES-1:0]     rsp_neg_mask,
    output logic                 rsp_sel_high,
    output logic [1:0]           rsp_precision,
    output logic                 busy
);

    localparam int unsigned      CntW    = $clog2(MUL_LATENCY + 1);
    localparam logic [CntW-1:0]  CntLoad = CntW'(MUL_LATENCY - 1);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);

    seq_state_e          state_q;
    logic [CntW-1:0]     cnt_q;
    logic [1:0]          dp_opcode_q;
    logic [1:0]          dp_precision_q;
    logic [31:0]         dp_operand_a_q;
    logic [31:0]         dp_operand_b_q;
    logic                mul_start_q;
    logic                rsp_valid_q;
    logic [LANES-1:0]    rsp_neg_mask_q;
    logic                rsp_sel_high_q;
    logic [1:0]          rsp_precision_q;
    logic                busy_q;

    logic                ready_c;
    logic                accept;

    // Ready in RESP follows rsp_ready combinationally so a new op can be taken on the
    // same edge the current response retires.
    always_comb begin
        ready_c = 1'b0;
        if (!rst) begin
            ready_c = (state_q == StIdle) || ((state_q == StResp) && rsp_ready);
        end
        accept = ready_c && req_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            dp_opcode_q     <= '0;
            dp_precision_q  <= '0;
            dp_operand_a_q  <= '0;
            dp_operand_b_q  <= '0;
            mul_start_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_neg_mask_q  <= '0;
            rsp_sel_high_q  <= 1'b0;
            rsp_precision_q <= '0;
            busy_q          <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;

            // dp_* only move on an accepted request; the array reads them live until then.
            if (accept) begin
                dp_opcode_q    <= req_opcode;
                dp_precision_q <= req_precision;
                dp_operand_a_q <= req_operand_a;
                dp_operand_b_q <= req_operand_b;
            end

            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StCond;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StCond: begin
                    // Conditioning already zeroed flags of unsigned operands and replicated
                    // them per lane, so a plain XOR gives the product sign at any precision.
                    rsp_neg_mask_q  <= dp_sign_a ^ dp_sign_b;
                    rsp_sel_high_q  <= is_high_half(opcode_e'(dp_opcode_q));
                    rsp_precision_q <= dp_precision_q;
                    cnt_q           <= CntLoad;
                    state_q         <= StMul;
                end
                StMul: begin
                    if (cnt_q == '0) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (req_valid) begin
                            state_q     <= StCond;
                            mul_start_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = ready_c;
    assign dp_opcode     = dp_opcode_q;
    assign dp_precision  = dp_precision_q;
    assign dp_operand_a  = dp_operand_a_q;
    assign dp_operand_b  = dp_operand_b_q;
    assign mul_start     = mul_start_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_neg_mask  = rsp_neg_mask_q;
    assign rsp_sel_high  = rsp_sel_high_q;
    assign rsp_precision = rsp_precision_q;
    assign busy          = busy_q;

endmodule
